level_decode_gen: RTL and testbench
===================================

Name: level_decode_gen

Overview:
- Parametrised CAVLC level decoder for one residual block.
- Sign-decodes the trailing ones, then decodes the remaining level_prefix/level_suffix codewords for every SuffixLength 0..6, including the prefix-14 and prefix-15 escape codes.
- Sits between the bitstream shifter and the coefficient run/reorder stage.
- Consumes one codeword per cycle with no stall cycles and delivers levels through a valid/ready output register.

Parameters:
- MAX_COEFF, 16: maximum TotalCoeff accepted. 16 for luma/AC blocks, 4 for chroma DC.
- LEVEL_W, 16: signed width of LevelOut. Minimum 14.
- WIN_W, 32: width of the bitstream window. Minimum 28, which covers a 16-bit prefix plus a 12-bit suffix.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; latches TotalCoeff and TrailingOnes
- TotalCoeff  in  5  number of non-zero coefficients
- TrailingOnes  in  2  number of trailing ±1 coefficients
- Bitstream  in  WIN_W  next unconsumed bits, MSB first
- BitsValid  in  1  Bitstream is valid this cycle
- NumShift  out  5  bits consumed this cycle
- ShiftEn  out  1  shifter advances by NumShift at this clock edge
- LevelOut  out  LEVEL_W  signed level, two's complement
- LevelIdx  out  5  index of LevelOut in decode order, 0 = highest frequency
- LevelValid  out  1  output register holds a level
- LevelReady  in  1  downstream accepts the level
- Busy  out  1  a block is in progress
- Done  out  1  one-cycle pulse when the last level is accepted
- Error  out  1  sticky until next Start; set on an illegal codeword

Behaviour:
- Reset: all state and outputs go to 0, FSM goes to IDLE. Reset mid-block abandons the block and does not pulse Done.
- FSM states:
  - IDLE: wait for Start.
  - T1SIGN: decode the trailing-one signs.
  - LEVEL: decode the remaining levels.
  - DRAIN: empty the output register, then pulse Done and return to IDLE.
- Start in IDLE:
  - Latch TotalCoeff and TrailingOnes; clear counters and Error.
  - If TotalCoeff > MAX_COEFF or TrailingOnes > TotalCoeff: set Error, stay in IDLE, no Done.
  - If TotalCoeff == 0: go to DRAIN; Done pulses on the next cycle.
  - Otherwise go to T1SIGN, or to LEVEL when TrailingOnes == 0.
- Start outside IDLE is ignored.
- fire = state in {T1SIGN, LEVEL} && BitsValid && (!LevelValid || LevelReady).
  - ShiftEn = fire. NumShift is meaningful only when ShiftEn is high, otherwise 0.
  - On fire, the decoded level loads the output register; LevelValid goes high on the next cycle, giving 1-cycle latency.
- T1SIGN:
  - NumShift = 1. Bitstream MSB 0 gives +1, MSB 1 gives -1.
  - After TrailingOnes fires: go to LEVEL, or to DRAIN if all coefficients are done.
- LEVEL:
  - Initial SuffixLength (sL) = 1 if TotalCoeff > 10 and TrailingOnes < 3, else 0.
  - prefix = number of leading zeros in Bitstream. No 1 within the top 16 bits: set Error and go to IDLE, no Done. The output register is discarded.
  - suffixSize = 4 if (sL == 0 and prefix == 14); 12 if prefix == 15; otherwise sL.
  - levelCode = (prefix << sL) + suffix, where suffix is the suffixSize bits after the 1.
    - Add 15 if sL == 0 and prefix == 15.
    - Add 2 on the first LEVEL codeword when TrailingOnes < 3.
  - Level value: (levelCode + 2) >> 1 if levelCode is even; -((levelCode + 1) >> 1) if odd.
  - NumShift = prefix + 1 + suffixSize; the maximum is 28.
  - sL update after each fire:
    - if sL == 0, sL becomes 1;
    - then, if |level| > (3 << (sL - 1)) and sL < 6, sL increments by 1.
    - Both steps apply in the same cycle.
- LevelIdx counts fires from 0. After TotalCoeff fires, go to DRAIN.
- Done pulses in the cycle LevelValid && LevelReady accepts the level with LevelIdx == TotalCoeff - 1.
- LevelOut and LevelIdx hold stable while LevelValid is high and LevelReady is low.

Decomposition:
- Package cavlc_pkg holds:
  - the FSM state enum;
  - the constants ESC_PREFIX_14 = 14, ESC_PREFIX_15 = 15, ESC_SUFFIX_W = 12, MAX_SUFFIX_LEN = 6.
- Sub-module level_prefix_finder: combinational leading-zero count over the top 16 window bits, with a found flag. It replaces OneFinder.

Test Plan:
- TotalCoeff=3, TrailingOnes=3, Bitstream MSBs 010 -> LevelOut +1, -1, +1; NumShift=1 each; Done on the 3rd accept.
- TotalCoeff=1, TrailingOnes=0, Bitstream MSB 1 -> levelCode 2, LevelOut +2, NumShift=1, Done.
- TotalCoeff=4, TrailingOnes=3, signs 000, then 13 zeros + 1 + 0101 (sL 0, prefix 14) -> levelCode 19, LevelOut -10, NumShift=19; Done on the 4th accept.
- TotalCoeff=11, TrailingOnes=1, start sL=1, prefix 15 + 12-bit suffix 0x005 -> levelCode 37, LevelOut -19, NumShift=28; next sL=2.
- LevelReady low for 3 cycles with LevelValid high -> ShiftEn=0 and LevelOut/LevelIdx held; resumes with one fire per cycle after LevelReady rises.
- TotalCoeff=2, TrailingOnes=0, top 16 window bits all zero -> Error=1, Busy=0, no Done. Start with TotalCoeff=17 -> Error=1 immediately.

Source files
------------

// File: rtl/cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cavlc_pkg
// Purpose  : Shared FSM state type and CAVLC level-coding constants.
// Revision : 1.0 - initial release
// ============================================================================
package cavlc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_T1SIGN = 2'd1,
        ST_LEVEL  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int ESC_PREFIX_14  = 14;
    localparam int ESC_PREFIX_15  = 15;
    localparam int ESC_SUFFIX_W   = 12;
    localparam int MAX_SUFFIX_LEN = 6;

endpackage
`default_nettype wire

// File: rtl/level_prefix_finder.sv
`default_nettype none
// ============================================================================
// Module   : level_prefix_finder
// Purpose  : Leading-zero count over the top 16 window bits, with found flag.
// Revision : 1.0 - initial release
// ============================================================================
module level_prefix_finder (
    input  logic [15:0] win_top,
    output logic [3:0]  prefix,
    output logic        found
);

    always_comb begin
        prefix = 4'd0;
        found  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && win_top[15-i]) begin
                prefix = 4'(i);
                found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/level_decode_gen.sv
`default_nettype none
// ============================================================================
// Module   : level_decode_gen
// Purpose  : CAVLC level decoder: trailing-one signs, then prefix/suffix levels.
// Revision : 1.0 - initial release
// ============================================================================
module level_decode_gen
    import cavlc_pkg::*;
#(
    parameter int MAX_COEFF = 16,
    parameter int LEVEL_W   = 16,
    parameter int WIN_W     = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [4:0]         TotalCoeff,
    input  logic [1:0]         TrailingOnes,
    input  logic [WIN_W-1:0]   Bitstream,
    input  logic               BitsValid,
    output logic [4:0]         NumShift,
    output logic               ShiftEn,
    output logic [LEVEL_W-1:0] LevelOut,
    output logic [4:0]         LevelIdx,
    output logic               LevelValid,
    input  logic               LevelReady,
    output logic               Busy,
    output logic               Done,
    output logic               Error
);

    state_t             state_q, state_d;
    logic [4:0]         tc_q, tc_d;
    logic [1:0]         t1_q, t1_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2:0]         sl_q, sl_d;
    logic               first_q, first_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [4:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;

    logic [3:0]         prefix;
    logic               found;
    logic               go;
    logic               bad_code;
    logic               fire;
    logic               done;
    logic [4:0]         suffix_size;
    logic [7:0]         sh_amt;
    logic [11:0]        suffix_mask;
    logic [11:0]        suffix;
    logic [15:0]        level_code;
    logic [15:0]        level_mag;
    logic [LEVEL_W-1:0] mag_ext;
    logic [LEVEL_W-1:0] level_val;
    logic [LEVEL_W-1:0] sign_val;
    logic [2:0]         sl_base;
    logic [15:0]        sl_thresh;
    logic [2:0]         sl_next;
    logic [4:0]         num_shift_lvl;
    logic [4:0]         cnt_inc;

    level_prefix_finder u_prefix (
        .win_top (Bitstream[WIN_W-1 -: 16]),
        .prefix  (prefix),
        .found   (found)
    );

    // A codeword with no terminating 1 is never consumed, so it does not count as a fire.
    assign go       = ((state_q == ST_T1SIGN) || (state_q == ST_LEVEL)) && BitsValid
                      && (!valid_q || LevelReady);
    assign bad_code = go && (state_q == ST_LEVEL) && !found;
    assign fire     = go && !bad_code;
    assign cnt_inc  = cnt_q + 5'd1;

    always_comb begin
        if (prefix == 4'(ESC_PREFIX_15)) begin
            suffix_size = 5'(ESC_SUFFIX_W);
        end else if ((sl_q == 3'd0) && (prefix == 4'(ESC_PREFIX_14))) begin
            suffix_size = 5'd4;
        end else begin
            suffix_size = {2'b00, sl_q};
        end
    end

    // Suffix sits right after the terminating 1; shift it down to bit 0 and mask.
    assign sh_amt      = 8'(WIN_W - 1) - {4'b0000, prefix} - {3'b000, suffix_size};
    assign suffix_mask = (12'd1 << suffix_size) - 12'd1;
    assign suffix      = 12'(Bitstream >> sh_amt) & suffix_mask;

    assign level_code = (16'(prefix) << sl_q) + 16'(suffix)
                      + (((sl_q == 3'd0) && (prefix == 4'(ESC_PREFIX_15))) ? 16'd15 : 16'd0)
                      + ((first_q && (t1_q != 2'd3)) ? 16'd2 : 16'd0);

    assign level_mag     = level_code[0] ? ((level_code + 16'd1) >> 1) : ((level_code + 16'd2) >> 1);
    assign mag_ext       = LEVEL_W'(level_mag);
    assign level_val     = level_code[0] ? (~mag_ext + LEVEL_W'(1)) : mag_ext;
    assign sign_val      = Bitstream[WIN_W-1] ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
    assign num_shift_lvl = {1'b0, prefix} + 5'd1 + suffix_size;

    assign sl_base   = (sl_q == 3'd0) ? 3'd1 : sl_q;
    assign sl_thresh = 16'd3 << (sl_base - 3'd1);
    assign sl_next   = ((level_mag > sl_thresh) && (sl_base < 3'(MAX_SUFFIX_LEN))) ?
                       (sl_base + 3'd1) : sl_base;

    assign done = (state_q == ST_DRAIN) && (!valid_q || LevelReady);

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        t1_d    = t1_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        first_d = first_q;
        level_d = level_q;
        idx_d   = idx_q;
        valid_d = valid_q && !LevelReady;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    tc_d    = TotalCoeff;
                    t1_d    = TrailingOnes;
                    cnt_d   = 5'd0;
                    idx_d   = 5'd0;
                    first_d = 1'b1;
                    error_d = 1'b0;
                    sl_d    = ((TotalCoeff > 5'd10) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
                    if ((TotalCoeff > 5'(MAX_COEFF)) || ({3'b000, TrailingOnes} > TotalCoeff)) begin
                        error_d = 1'b1;
                    end else if (TotalCoeff == 5'd0) begin
                        state_d = ST_DRAIN;
                    end else if (TrailingOnes == 2'd0) begin
                        state_d = ST_LEVEL;
                    end else begin
                        state_d = ST_T1SIGN;
                    end
                end
            end
            ST_T1SIGN: begin
                if (fire) begin
                    level_d = sign_val;
                    idx_d   = cnt_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == {3'b000, t1_q}) begin
                        state_d = (cnt_inc == tc_q) ? ST_DRAIN : ST_LEVEL;
                    end
                end
            end
            ST_LEVEL: begin
                if (bad_code) begin
                    error_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (fire) begin
                    level_d = level_val;
                    idx_d   = cnt_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    sl_d    = sl_next;
                    first_d = 1'b0;
                    if (cnt_inc == tc_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            tc_q    <= 5'd0;
            t1_q    <= 2'd0;
            cnt_q   <= 5'd0;
            sl_q    <= 3'd0;
            first_q <= 1'b0;
            level_q <= '0;
            idx_q   <= 5'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            t1_q    <= t1_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            first_q <= first_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign ShiftEn    = fire;
    assign NumShift   = fire ? ((state_q == ST_T1SIGN) ? 5'd1 : num_shift_lvl) : 5'd0;
    assign LevelOut   = level_q;
    assign LevelIdx   = idx_q;
    assign LevelValid = valid_q;
    assign Busy       = (state_q != ST_IDLE);
    assign Done       = done;
    assign Error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_level_decode_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_decode_gen
// Purpose  : Self-checking bench for level_decode_gen against a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_decode_gen;

    localparam int WIN_W     = 32;
    localparam int LEVEL_W   = 16;
    localparam int MAX_COEFF = 16;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Start;
    logic [4:0]         TotalCoeff;
    logic [1:0]         TrailingOnes;
    logic [WIN_W-1:0]   Bitstream;
    logic               BitsValid;
    logic [4:0]         NumShift;
    logic               ShiftEn;
    logic [LEVEL_W-1:0] LevelOut;
    logic [4:0]         LevelIdx;
    logic               LevelValid;
    logic               LevelReady;
    logic               Busy;
    logic               Done;
    logic               Error;

    level_decode_gen #(
        .MAX_COEFF (MAX_COEFF),
        .LEVEL_W   (LEVEL_W),
        .WIN_W     (WIN_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .Bitstream    (Bitstream),
        .BitsValid    (BitsValid),
        .NumShift     (NumShift),
        .ShiftEn      (ShiftEn),
        .LevelOut     (LevelOut),
        .LevelIdx     (LevelIdx),
        .LevelValid   (LevelValid),
        .LevelReady   (LevelReady),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int fails  = 0;
    bit bits[$];
    int exp_lvl[$];
    int exp_sh[$];
    bit exp_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit bit_at(input int i);
        return (i < bits.size()) ? bits[i] : 1'b0;
    endfunction

    task automatic push_bits(input int val, input int n);
        for (int k = n - 1; k >= 0; k--) bits.push_back(bit'((val >> k) & 1));
    endtask

    task automatic push_random(input int n);
        for (int k = 0; k < n; k++) bits.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Reads the bit queue codeword by codeword using the level-coding rules.
    function automatic void model(input int tc, input int t1);
        int p, sl, pre, ss, suf, lc, lvl, sh, mag;
        exp_lvl.delete();
        exp_sh.delete();
        exp_err = 1'b0;
        if (tc > MAX_COEFF || t1 > tc) begin
            exp_err = 1'b1;
            return;
        end
        p  = 0;
        sl = (tc > 10 && t1 < 3) ? 1 : 0;
        for (int i = 0; i < tc; i++) begin
            if (i < t1) begin
                lvl = bit_at(p) ? -1 : 1;
                sh  = 1;
            end else begin
                pre = 0;
                while (pre < 16 && bit_at(p + pre) == 1'b0) pre++;
                if (pre == 16) begin
                    exp_err = 1'b1;
                    return;
                end
                if (pre == 15)                 ss = 12;
                else if (sl == 0 && pre == 14) ss = 4;
                else                           ss = sl;
                suf = 0;
                for (int k = 0; k < ss; k++) suf = suf * 2 + int'(bit_at(p + pre + 1 + k));
                lc = pre * (1 << sl) + suf;
                if (sl == 0 && pre == 15) lc += 15;
                if (i == t1 && t1 < 3)    lc += 2;
                if (lc % 2 == 0) lvl = (lc + 2) / 2;
                else             lvl = -((lc + 1) / 2);
                sh  = pre + 1 + ss;
                mag = (lvl < 0) ? -lvl : lvl;
                if (sl == 0) sl = 1;
                if (mag > 3 * (1 << (sl - 1)) && sl < 6) sl++;
            end
            exp_lvl.push_back(lvl);
            exp_sh.push_back(sh);
            p += sh;
        end
    endfunction

    // mode 0: always valid/ready; 1: ready low for cycles 2..4; 2: random valid/ready.
    task automatic run_block(input int tc, input int t1, input int mode);
        int pos = 0, acc = 0, fires = 0, dones = 0;
        bit timeout = 1'b1;
        bit held = 1'b0;
        int held_lvl = 0, held_idx = 0;
        model(tc, t1);
        @(negedge Clk);
        Start        = 1'b1;
        TotalCoeff   = 5'(tc);
        TrailingOnes = 2'(t1);
        BitsValid    = 1'b0;
        LevelReady   = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < WIN_W; j++) Bitstream[WIN_W-1-j] = bit_at(pos + j);
            case (mode)
                1: begin
                    BitsValid  = 1'b1;
                    LevelReady = !(cyc >= 2 && cyc <= 4);
                end
                2: begin
                    BitsValid  = ($urandom_range(0, 3) != 0);
                    LevelReady = ($urandom_range(0, 2) != 0);
                end
                default: begin
                    BitsValid  = 1'b1;
                    LevelReady = 1'b1;
                end
            endcase
            #1;
            if (!Busy) begin
                timeout = 1'b0;
                break;
            end
            if (held && LevelValid) begin
                chk("hold_level", int'($signed(LevelOut)), held_lvl);
                chk("hold_idx", int'(LevelIdx), held_idx);
            end
            if (!ShiftEn) chk("numshift_idle", int'(NumShift), 0);
            if (LevelValid && !LevelReady) chk("no_shift_on_stall", int'(ShiftEn), 0);
            if (!BitsValid) chk("no_shift_no_bits", int'(ShiftEn), 0);
            if (ShiftEn) begin
                if (fires < exp_sh.size()) chk("numshift", int'(NumShift), exp_sh[fires]);
                else                       chk("extra_fire", fires, exp_sh.size());
                pos += int'(NumShift);
                fires++;
            end
            if (LevelValid && LevelReady) begin
                if (acc < exp_lvl.size()) begin
                    chk("level_out", int'($signed(LevelOut)), exp_lvl[acc]);
                    chk("level_idx", int'(LevelIdx), acc);
                end else begin
                    chk("extra_level", acc, exp_lvl.size());
                end
                acc++;
            end
            if (Done) begin
                dones++;
                chk("done_on_last",
                    int'((LevelValid && LevelReady && int'(LevelIdx) == tc - 1) ||
                         (tc == 0 && !LevelValid)), 1);
            end
            held     = LevelValid && !LevelReady;
            held_lvl = int'($signed(LevelOut));
            held_idx = int'(LevelIdx);
            @(negedge Clk);
        end
        chk("block_timeout", int'(timeout), 0);
        if (exp_err) begin
            chk("error_flag", int'(Error), 1);
            chk("no_done_on_error", dones, 0);
        end else begin
            chk("error_clear", int'(Error), 0);
            chk("accepted_count", acc, tc);
            chk("done_count", dones, 1);
        end
        BitsValid = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        Start        = 1'b0;
        TotalCoeff   = 5'd0;
        TrailingOnes = 2'd0;
        Bitstream    = '0;
        BitsValid    = 1'b0;
        LevelReady   = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_valid", int'(LevelValid), 0);
        chk("rst_error", int'(Error), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_shiften", int'(ShiftEn), 0);
        chk("rst_level", int'(LevelOut), 0);
        Reset = 1'b0;

        // Three trailing ones, signs 0,1,0
        bits.delete();
        push_bits(3'b010, 3);
        model(3, 3);
        chk("pin_t1_0", exp_lvl[0], 1);
        chk("pin_t1_1", exp_lvl[1], -1);
        chk("pin_t1_2", exp_lvl[2], 1);
        run_block(3, 3, 0);

        // Single level with the first-codeword +2 bonus
        bits.delete();
        push_bits(1, 1);
        model(1, 0);
        chk("pin_l2", exp_lvl[0], 2);
        chk("pin_l2_sh", exp_sh[0], 1);
        run_block(1, 0, 0);

        // Prefix-14 escape at sL 0
        bits.delete();
        push_bits(3'b000, 3);
        push_bits(0, 14);
        push_bits(1, 1);
        push_bits(4'b0101, 4);
        model(4, 3);
        chk("pin_p14_lvl", exp_lvl[3], -10);
        chk("pin_p14_sh", exp_sh[3], 19);
        run_block(4, 3, 0);

        // Prefix-15 escape at sL 1, then a 1+00 codeword that only sL 2 reads as 3 bits
        bits.delete();
        push_bits(1, 1);
        push_bits(0, 15);
        push_bits(1, 1);
        push_bits(12'h005, 12);
        push_bits(3'b100, 3);
        push_random(250);
        model(11, 1);
        chk("pin_p15_sign", exp_lvl[0], -1);
        chk("pin_p15_lvl", exp_lvl[1], -19);
        chk("pin_p15_sh", exp_sh[1], 28);
        chk("pin_sl2_sh", exp_sh[2], 3);
        chk("pin_sl2_lvl", exp_lvl[2], 1);
        run_block(11, 1, 0);

        // Backpressure: ready low for three cycles while a level is held
        bits.delete();
        push_bits(1, 1);
        push_random(200);
        model(5, 0);
        chk("pin_stall_first", exp_lvl[0], 2);
        run_block(5, 0, 1);

        // Missing terminating 1 within the top 16 bits
        bits.delete();
        push_bits(0, 32);
        run_block(2, 0, 0);
        chk("err_busy", int'(Busy), 0);

        // Illegal parameters
        bits.delete();
        run_block(17, 0, 0);
        run_block(1, 2, 0);

        // Empty block
        run_block(0, 0, 0);

        // Longer random blocks exercising suffix-length growth
        for (int r = 0; r < 3; r++) begin
            bits.delete();
            push_random(520);
            run_block(16, r, 2);
        end
        bits.delete();
        push_random(400);
        run_block(12, 3, 0);

        // Reset mid-block abandons without Done
        bits.delete();
        push_random(64);
        @(negedge Clk);
        Start        = 1'b1;
        TotalCoeff   = 5'd16;
        TrailingOnes = 2'd0;
        @(negedge Clk);
        Start      = 1'b0;
        BitsValid  = 1'b1;
        LevelReady = 1'b0;
        for (int j = 0; j < WIN_W; j++) Bitstream[WIN_W-1-j] = bit_at(j);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_valid", int'(LevelValid), 0);
        chk("midrst_done", int'(Done), 0);
        Reset     = 1'b0;
        BitsValid = 1'b0;
        @(negedge Clk);
        chk("midrst_idle_done", int'(Done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
